sccb_init_seq: RTL and testbench
================================

SCCB_INIT_SEQ -- requirements
Module: sccb_init_seq

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 64, init table depth (max 256).
REQ-002 SHALL have parameter UNIT_CYCLES, default 50000, PCLK cycles per delay unit.
REQ-003 SHALL have parameter POLL_GAP, default 16, idle PCLK cycles between status polls.
REQ-004 SHALL have parameter POLL_LIMIT, default 4096, maximum polls per write before timeout.
REQ-005 SHALL have ports:
 PCLK  in  1  clock
 PRESETN  in  1  reset, asynchronous, active-low
 START  in  1  one-cycle pulse, begins table walk
 BUSY  out  1  walk in progress
 DONE  out  1  walk completed without error, sticky until next START
 ERR  out  1  PSLVERR or poll timeout seen, sticky until next START
 IDX  out  8  index of current or last table entry
 PSEL, PENABLE, PWRITE  out  1 each  APB master controls toward SCCB APB slave
 PADDR  out  8  APB address
 PWDATA  out  24  {dev_id, reg_addr, reg_data}
 PRDATA  in  8  APB read data
 PREADY, PSLVERR  in  1 each  APB slave response

Function
REQ-006 SHALL walk table entries 0..N_ENTRIES-1, each 24-bit {id[23:16], reg[15:8], data[7:0]}.
REQ-007 Entry with id!=0x00 SHALL be a register write: APB write of the entry to CMD_ADDR 0x00, then poll STAT_ADDR 0x04 until PRDATA[0]=0 (SCCB idle).
REQ-008 Entry id=0x00, reg=0x00 SHALL terminate the walk (DONE); id=0x00, reg=0x01 SHALL wait data*UNIT_CYCLES cycles (data=0 means no wait); other id=0x00 entries SHALL be skipped.
REQ-009 Reaching index N_ENTRIES without terminator SHALL terminate with DONE.
REQ-010 States: IDLE, FETCH, W_SETUP, W_ACCESS, GAP, R_SETUP, R_ACCESS, DELAY, FIN, FAIL.
REQ-011 IDLE: START -> FETCH, IDX=0, DONE=ERR=0, BUSY=1 next cycle; START while BUSY SHALL be ignored.
REQ-012 FETCH: one cycle synchronous table read, then decode per REQ-007/008.
REQ-013 SETUP states SHALL drive PSEL=1, PENABLE=0 for exactly one cycle; ACCESS states PSEL=1, PENABLE=1, PADDR/PWRITE/PWDATA stable, held until PREADY=1.
REQ-014 Between APB transfers PSEL=PENABLE=0; no back-to-back transfer without a SETUP phase.
REQ-015 W_ACCESS complete -> GAP; GAP lasts POLL_GAP cycles -> R_SETUP; R_ACCESS complete with PRDATA[0]=1 -> GAP, with PRDATA[0]=0 -> next entry FETCH, IDX+1.
REQ-016 PSLVERR=1 with PREADY=1 in any ACCESS state SHALL go to FAIL: ERR=1, BUSY=0, IDX frozen.
REQ-017 POLL_LIMIT polls without idle SHALL go to FAIL.
REQ-018 FIN: DONE=1, BUSY=0, return to IDLE; START in IDLE after FIN or FAIL restarts from entry 0.
REQ-019 Delay counter SHALL be 32 bits, no wrap for data<=255 at default UNIT_CYCLES.

Reset
REQ-020 PRESETN low SHALL asynchronously force IDLE, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, BUSY=DONE=ERR=0, IDX=0, all counters 0, including mid-transfer.

Structure
REQ-021 Shared package SHALL hold CMD_ADDR, STAT_ADDR, entry opcode constants (END=0x00, DELAY=0x01), and state encoding.
REQ-022 Table SHALL be a sub-module sccb_init_rom (index in, 24-bit entry out, registered, one-cycle latency).

Verification
REQ-023 Table {60_12_80, 00_01_02, 60_56_E3, 00_00_00}, UNIT_CYCLES=10, slave idle after 3 polls -> two APB writes with PWDATA 0x601280 then 0x6056E3, >=20 cycle gap between, DONE=1, IDX=3.
REQ-024 PSLVERR asserted on second write -> ERR=1, DONE=0, BUSY=0, IDX=1, no further PSEL.
REQ-025 Status stuck busy, POLL_LIMIT=8 -> exactly 8 reads to 0x04, then ERR=1.
REQ-026 PREADY held low 5 cycles in W_ACCESS -> PENABLE, PADDR, PWDATA stable all 5 cycles.
REQ-027 PRESETN pulsed low during R_ACCESS -> PSEL=0 same cycle; START after release walks from IDX=0.

Source files
------------

// File: rtl/sccb_init_seq_pkg.sv
// Shared definitions for the SCCB init-table sequencer.
//   - APB register map of the SCCB master (command and status addresses)
//   - control-entry opcodes (entries whose device id is 0x00)
//   - table entry layout and sequencer state encoding
//   - helper to turn a delay count into PCLK cycles
package sccb_init_seq_pkg;

  localparam int ENTRY_W     = 24;
  localparam int MAX_ENTRIES = 256;

  localparam logic [7:0] CMD_ADDR  = 8'h00;
  localparam logic [7:0] STAT_ADDR = 8'h04;

  // An entry with this device id is a control entry, not a register write.
  localparam logic [7:0] ID_CTRL   = 8'h00;
  localparam logic [7:0] OP_END    = 8'h00;
  localparam logic [7:0] OP_DELAY  = 8'h01;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] rg;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_W_SETUP,
    S_W_ACCESS,
    S_GAP,
    S_R_SETUP,
    S_R_ACCESS,
    S_DELAY,
    S_FIN,
    S_FAIL
  } state_e;

  // 255 units at 50000 cycles stays below 2^32, so no wrap in practice.
  function automatic logic [31:0] delay_cycles(input logic [7:0]  units,
                                               input logic [31:0] unit_cycles);
    return 32'(units) * unit_cycles;
  endfunction

endpackage

// File: rtl/sccb_init_rom.sv
// Init table storage for the SCCB sequencer.
// Ports:
//   clk   - clock
//   idx   - entry index to read
//   entry - registered table entry, valid one cycle after idx is presented
// Table contents come from INIT_TABLE, entry i packed at bits [i*24 +: 24].
// Indices at or beyond N_ENTRIES read as zero (an END entry).
module sccb_init_rom
  import sccb_init_seq_pkg::*;
#(
  parameter int                                 N_ENTRIES  = 64,
  parameter logic [MAX_ENTRIES*ENTRY_W-1:0]     INIT_TABLE = '0
) (
  input  logic       clk,
  input  logic [7:0] idx,
  output entry_t     entry
);

  logic [12:0] base;
  entry_t      entry_d;
  entry_t      entry_q;

  always_comb begin
    base    = 13'(idx) * 13'd24;
    entry_d = '0;
    if (32'(idx) < N_ENTRIES) begin
      entry_d = INIT_TABLE[base +: ENTRY_W];
    end
  end

  // Pure data register: no reset, the sequencer never decodes it before a fetch.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign entry = entry_q;

endmodule

// File: rtl/sccb_init_seq.sv
// SCCB init-table sequencer: walks a table of {dev_id, reg, data} entries and
// issues each register write to an APB-attached SCCB master, polling its status
// register until the bus goes idle. Control entries (id 0x00) end the walk or
// insert a timed delay.
// Ports:
//   PCLK, PRESETN         - clock, asynchronous active-low reset
//   START                 - one-cycle pulse, starts a walk from entry 0 (ignored while BUSY)
//   BUSY / DONE / ERR     - walk running / finished cleanly / slave error or poll timeout
//   IDX                   - current or last table index
//   PSEL..PWDATA          - APB master request
//   PRDATA, PREADY, PSLVERR - APB slave response
module sccb_init_seq
  import sccb_init_seq_pkg::*;
#(
  parameter int                             N_ENTRIES   = 64,
  parameter int                             UNIT_CYCLES = 50000,
  parameter int                             POLL_GAP    = 16,
  parameter int                             POLL_LIMIT  = 4096,
  parameter logic [MAX_ENTRIES*ENTRY_W-1:0] INIT_TABLE  = '0
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  IDX,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [23:0] PWDATA,
  input  logic [7:0]  PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [7:0]  paddr_q, paddr_d;
  logic [23:0] pwdata_q, pwdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] poll_q, poll_d;

  logic        go_gap;
  logic        go_read;
  logic        go_next;
  entry_t      entry;
  logic        prdata_unused;

  assign prdata_unused = ^PRDATA[7:1];

  // The ROM is addressed with the next index so the entry is already
  // registered by the time the FSM sits in FETCH.
  sccb_init_rom #(
    .N_ENTRIES  (N_ENTRIES),
    .INIT_TABLE (INIT_TABLE)
  ) u_rom (
    .clk   (PCLK),
    .idx   (idx_d),
    .entry (entry)
  );

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      cnt_q     <= '0;
      poll_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      cnt_q     <= cnt_d;
      poll_q    <= poll_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    cnt_d     = cnt_q;
    poll_d    = poll_q;
    go_gap    = 1'b0;
    go_read   = 1'b0;
    go_next   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_FETCH;
          idx_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          poll_d  = '0;
        end
      end
      S_FETCH: begin
        if (entry.id != ID_CTRL) begin
          state_d   = S_W_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = 1'b1;
          paddr_d   = CMD_ADDR;
          pwdata_d  = entry;
          poll_d    = '0;
        end else if (entry.rg == OP_END) begin
          state_d = S_FIN;
        end else if (entry.rg == OP_DELAY && entry.data != 8'h00) begin
          state_d = S_DELAY;
          cnt_d   = delay_cycles(entry.data, 32'(UNIT_CYCLES)) - 32'd1;
        end else begin
          // zero-length delay or unknown control opcode: nothing to do
          go_next = 1'b1;
        end
      end
      S_W_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_W_ACCESS;
      end
      S_W_ACCESS: begin
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          if (PSLVERR) state_d = S_FAIL;
          else         go_gap  = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) go_read = 1'b1;
        else             cnt_d   = cnt_q - 32'd1;
      end
      S_R_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_R_ACCESS;
      end
      S_R_ACCESS: begin
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (PSLVERR)                   state_d = S_FAIL;
          else if (!PRDATA[0])           go_next = 1'b1;
          else if (poll_q >= POLL_LIMIT) state_d = S_FAIL;
          else                           go_gap  = 1'b1;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) go_next = 1'b1;
        else             cnt_d   = cnt_q - 32'd1;
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A zero-length gap goes straight to the next status read.
    if (go_gap) begin
      if (POLL_GAP == 0) begin
        go_read = 1'b1;
      end else begin
        state_d = S_GAP;
        cnt_d   = 32'(POLL_GAP - 1);
      end
    end

    if (go_read) begin
      state_d   = S_R_SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      paddr_d   = STAT_ADDR;
      poll_d    = poll_q + 32'd1;
    end

    // IDX stays on the last entry when the table runs out without an END.
    if (go_next) begin
      if (32'(idx_q) >= N_ENTRIES - 1) begin
        state_d = S_FIN;
      end else begin
        idx_d   = idx_q + 8'd1;
        state_d = S_FETCH;
      end
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;
  assign IDX     = idx_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Directed bench for sccb_init_seq. Two instances share clock and reset:
//   u_dut_a : table {601280, 000102, 6056E3, 000000}, UNIT_CYCLES=10
//   u_dut_b : table {601280, 6056E3, 000000}, POLL_LIMIT=8
// Each has a small reactive APB slave whose wait states, busy-poll count and
// error-on-Nth-write are set per scenario.
module tb_sccb_init_seq;

  localparam logic [6143:0] TAB_A =
    6144'({24'h000000, 24'h6056E3, 24'h000102, 24'h601280});
  localparam logic [6143:0] TAB_B =
    6144'({24'h000000, 24'h6056E3, 24'h601280});

  logic        clk;
  logic        rst_n;
  logic        start   [2];
  logic        busy    [2];
  logic        done    [2];
  logic        err     [2];
  logic [7:0]  idx     [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [7:0]  paddr   [2];
  logic [23:0] pwdata  [2];
  logic [7:0]  prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  // slave knobs
  int wait_n [2];
  int busy_n [2];
  int err_wr [2];

  // slave / monitor state
  logic        clr;
  logic        watch_psel;
  int          cyc;
  int          acc_cnt    [2];
  int          poll_cnt   [2];
  int          wr_cnt     [2];
  int          rd_cnt     [2];
  int          psel_after [2];
  logic [23:0] wr_log     [2][4];
  int          setup_cyc  [2][4];
  int          done_cyc   [2][4];
  int          stall_n;
  int          stall_bad;

  int n_total;
  int n_bad;

  sccb_init_seq #(
    .N_ENTRIES(4), .UNIT_CYCLES(10), .POLL_GAP(16), .POLL_LIMIT(4096),
    .INIT_TABLE(TAB_A)
  ) u_dut_a (
    .PCLK(clk), .PRESETN(rst_n), .START(start[0]),
    .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0]), .IDX(idx[0]),
    .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]),
    .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );

  sccb_init_seq #(
    .N_ENTRIES(3), .UNIT_CYCLES(10), .POLL_GAP(16), .POLL_LIMIT(8),
    .INIT_TABLE(TAB_B)
  ) u_dut_b (
    .PCLK(clk), .PRESETN(rst_n), .START(start[1]),
    .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1]), .IDX(idx[1]),
    .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]),
    .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : g_slv
    assign pready[g]  = (acc_cnt[g] >= wait_n[g]);
    assign prdata[g]  = {7'd0, (poll_cnt[g] < busy_n[g])};
    assign pslverr[g] = psel[g] & penable[g] & pwrite[g] & (err_wr[g] == wr_cnt[g] + 1);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        acc_cnt[i]    <= 0;
        poll_cnt[i]   <= 0;
        wr_cnt[i]     <= 0;
        rd_cnt[i]     <= 0;
        psel_after[i] <= 0;
      end else begin
        if (watch_psel && psel[i]) psel_after[i] <= psel_after[i] + 1;
        if (psel[i] && !penable[i] && pwrite[i] && wr_cnt[i] < 4)
          setup_cyc[i][wr_cnt[i]] <= cyc;
        if (psel[i] && penable[i]) begin
          if (!pready[i]) begin
            acc_cnt[i] <= acc_cnt[i] + 1;
          end else begin
            acc_cnt[i] <= 0;
            if (pwrite[i]) begin
              if (wr_cnt[i] < 4) begin
                wr_log[i][wr_cnt[i]]   <= pwdata[i];
                done_cyc[i][wr_cnt[i]] <= cyc;
              end
              wr_cnt[i]   <= wr_cnt[i] + 1;
              poll_cnt[i] <= 0;
            end else begin
              poll_cnt[i] <= poll_cnt[i] + 1;
              if (paddr[i] == 8'h04) rd_cnt[i] <= rd_cnt[i] + 1;
            end
          end
        end
      end
    end
  end

  // Stalled first write on instance A: request must hold address and data.
  always @(negedge clk) begin
    if (psel[0] && penable[0] && !pready[0] && pwrite[0] && wr_cnt[0] == 0) begin
      stall_n <= stall_n + 1;
      if (paddr[0] !== 8'h00 || pwdata[0] !== 24'h601280) stall_bad <= stall_bad + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic clr_model();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    while (busy[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("walk_ends_in_budget", 32'(busy[i]), 32'd0);
  endtask

  initial begin
    int gap;
    int n;
    n_total    = 0;
    n_bad      = 0;
    cyc        = 0;
    stall_n    = 0;
    stall_bad  = 0;
    clr        = 1'b0;
    watch_psel = 1'b0;
    rst_n      = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i]  = 1'b0;
      wait_n[i] = 0;
      busy_n[i] = 0;
      err_wr[i] = 0;
    end
    repeat (3) @(negedge clk);

    // reset state
    check_eq("rst_busy",   32'(busy[0]),    32'd0);
    check_eq("rst_done",   32'(done[0]),    32'd0);
    check_eq("rst_err",    32'(err[0]),     32'd0);
    check_eq("rst_idx",    32'(idx[0]),     32'd0);
    check_eq("rst_psel",   32'(psel[0]),    32'd0);
    check_eq("rst_pwdata", 32'(pwdata[0]),  32'd0);
    rst_n = 1'b1;
    clr_model();

    // two writes around a 20-cycle delay, slave idle on the third poll
    busy_n[0] = 2;
    pulse_start(0);
    check_eq("a_busy_after_start", 32'(busy[0]), 32'd1);
    repeat (30) @(negedge clk);
    pulse_start(0);                     // ignored while busy
    wait_idle(0, 3000);
    gap = setup_cyc[0][1] - done_cyc[0][0];
    check_eq("a_writes",   32'(wr_cnt[0]),    32'd2);
    check_eq("a_wdata0",   32'(wr_log[0][0]), 32'h601280);
    check_eq("a_wdata1",   32'(wr_log[0][1]), 32'h6056E3);
    check_eq("a_gap_ge20", 32'(gap >= 20),    32'd1);
    check_eq("a_reads",    32'(rd_cnt[0]),    32'd6);
    check_eq("a_done",     32'(done[0]),      32'd1);
    check_eq("a_err",      32'(err[0]),       32'd0);
    check_eq("a_idx",      32'(idx[0]),       32'd3);
    check_eq("a_psel_idle", 32'(psel[0]),     32'd0);

    // slave error on the second write
    clr_model();
    err_wr[1] = 2;
    pulse_start(1);
    wait_idle(1, 3000);
    check_eq("b_err",    32'(err[1]),    32'd1);
    check_eq("b_done",   32'(done[1]),   32'd0);
    check_eq("b_busy",   32'(busy[1]),   32'd0);
    check_eq("b_idx",    32'(idx[1]),    32'd1);
    check_eq("b_writes", 32'(wr_cnt[1]), 32'd2);
    watch_psel = 1'b1;
    repeat (40) @(negedge clk);
    watch_psel = 1'b0;
    check_eq("b_no_psel_after_fail", 32'(psel_after[1]), 32'd0);

    // status stuck busy, restart after FAIL
    clr_model();
    err_wr[1] = 0;
    busy_n[1] = 100000;
    pulse_start(1);
    check_eq("c_err_cleared", 32'(err[1]), 32'd0);
    wait_idle(1, 3000);
    check_eq("c_reads",  32'(rd_cnt[1]),    32'd8);
    check_eq("c_err",    32'(err[1]),       32'd1);
    check_eq("c_done",   32'(done[1]),      32'd0);
    check_eq("c_idx",    32'(idx[1]),       32'd0);
    check_eq("c_wdata0", 32'(wr_log[1][0]), 32'h601280);

    // five wait states on every access
    clr_model();
    wait_n[0] = 5;
    busy_n[0] = 0;
    stall_n   = 0;
    stall_bad = 0;
    pulse_start(0);
    wait_idle(0, 3000);
    check_eq("d_stall_cycles", 32'(stall_n),   32'd5);
    check_eq("d_stall_stable", 32'(stall_bad), 32'd0);
    check_eq("d_writes",       32'(wr_cnt[0]), 32'd2);
    check_eq("d_done",         32'(done[0]),   32'd1);

    // reset in the middle of a status read
    clr_model();
    wait_n[0] = 3;
    busy_n[0] = 5;
    pulse_start(0);
    n = 0;
    while (!(psel[0] && penable[0] && !pwrite[0]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("e_reached_raccess", 32'(psel[0] && penable[0] && !pwrite[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("e_rst_psel",    32'(psel[0]),    32'd0);
    check_eq("e_rst_penable", 32'(penable[0]), 32'd0);
    check_eq("e_rst_busy",    32'(busy[0]),    32'd0);
    check_eq("e_rst_done",    32'(done[0]),    32'd0);
    check_eq("e_rst_paddr",   32'(paddr[0]),   32'd0);
    check_eq("e_rst_pwdata",  32'(pwdata[0]),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n[0] = 0;
    busy_n[0] = 0;
    clr_model();
    pulse_start(0);
    check_eq("e_restart_busy", 32'(busy[0]), 32'd1);
    check_eq("e_restart_idx",  32'(idx[0]),  32'd0);
    wait_idle(0, 3000);
    check_eq("e_wdata0", 32'(wr_log[0][0]), 32'h601280);
    check_eq("e_writes", 32'(wr_cnt[0]),    32'd2);
    check_eq("e_done",   32'(done[0]),      32'd1);
    check_eq("e_idx",    32'(idx[0]),       32'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
